// File: rtl/izhikevich_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: one shared fixed-point Euler datapath
// walks every neuron in index order on each start pulse (READ -> CALC -> UPDATE).
module izhikevich_neuron_array #(
  parameter int N           = 18,
  parameter int Q           = 8,
  parameter int NUM_NEURONS = 4,
  parameter int A           = 5,
  parameter int B           = 51,
  parameter int C           = -(65 << Q),
  parameter int D           = 8 << Q,
  parameter int V_TH        = 30 << Q,
  parameter int V_INIT      = -(65 << Q),
  parameter int W_INIT      = -(13 << Q),
  localparam int IW         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N-1:0]               step,
  input  logic [N*NUM_NEURONS-1:0]   i_flat,
  input  logic                       load_en,
  input  logic [IW-1:0]              load_idx,
  input  logic [N-1:0]               load_v,
  input  logic [N-1:0]               load_w,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_NEURONS-1:0]     spikes,
  output logic [N*NUM_NEURONS-1:0]   v_flat,
  output logic [N*NUM_NEURONS-1:0]   w_flat
);

  localparam int W  = 4 * N;
  localparam int SH = 3 * Q;

  localparam logic signed [W-1:0] SMAX  = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN  = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [W-1:0] K_SQ  = W'(10);
  localparam logic signed [W-1:0] K_LIN = W'(5 << Q);
  localparam logic signed [W-1:0] K_C   = W'(140 << Q);
  localparam logic signed [W-1:0] KA    = W'(A);
  localparam logic signed [W-1:0] KB    = W'(B);
  localparam logic signed [W-1:0] KD    = W'(D);

  localparam logic signed [N-1:0] VTH_N  = N'(V_TH);
  localparam logic signed [N-1:0] C_N    = N'(C);
  localparam logic signed [N-1:0] VINI_N = N'(V_INIT);
  localparam logic signed [N-1:0] WINI_N = N'(W_INIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_UPDATE,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q;
  logic signed [N-1:0]    step_q;
  logic signed [N-1:0]    rv_q, rw_q, ri_q;
  logic signed [N-1:0]    vn_q, wn_q;
  logic signed [N-1:0]    vn_d, wn_d, wsp_d;
  logic signed [N-1:0]    v_q [NUM_NEURONS];
  logic signed [N-1:0]    w_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] spikes_q;
  logic                   last_idx;
  logic                   load_ok;

  logic signed [W-1:0]    vx, wx, ix, sx;
  logic signed [W-1:0]    acc, vsum, wacc, wsum;

  function automatic logic signed [W-1:0] sext(input logic signed [N-1:0] x);
    return W'(x);
  endfunction

  function automatic logic signed [N-1:0] sat(input logic signed [W-1:0] x);
    logic signed [W-1:0] y;
    if (x > SMAX)      y = SMAX;
    else if (x < SMIN) y = SMIN;
    else               y = x;
    return y[N-1:0];
  endfunction

  always_comb begin
    last_idx = (32'(idx_q) == 32'(NUM_NEURONS - 1));
    load_ok  = load_en && (state_q == S_IDLE) && (32'(load_idx) < 32'(NUM_NEURONS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_READ;
      S_READ:   state_d = S_CALC;
      S_CALC:   state_d = S_UPDATE;
      S_UPDATE: state_d = last_idx ? S_DONE : S_READ;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_READ) || (state_q == S_CALC) || (state_q == S_UPDATE);
    done = (state_q == S_DONE);
  end

  // Full-precision sums aligned at 3Q (v^2 term), scaled by step to 4Q, single
  // floor shift back to Q; adding v<<3Q before the shift equals v + floor(dv).
  always_comb begin
    vx    = sext(rv_q);
    wx    = sext(rw_q);
    ix    = sext(ri_q);
    sx    = sext(step_q);
    acc   = K_SQ * vx * vx + ((K_LIN * vx) <<< Q) + ((K_C - wx + ix) <<< (2 * Q));
    vsum  = (vx <<< SH) + acc * sx;
    vn_d  = sat(vsum >>> SH);
    wacc  = KA * (KB * vx - (wx <<< Q));
    wsum  = (wx <<< SH) + wacc * sx;
    wn_d  = sat(wsum >>> SH);
    wsp_d = sat(sext(wn_q) + KD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      step_q   <= '0;
      rv_q     <= '0;
      rw_q     <= '0;
      ri_q     <= '0;
      vn_q     <= '0;
      wn_q     <= '0;
      spikes_q <= '0;
      for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
        v_q[k] <= VINI_N;
        w_q[k] <= WINI_N;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_ok) begin
            v_q[load_idx] <= load_v;
            w_q[load_idx] <= load_w;
          end
          if (start) begin
            step_q   <= step;
            spikes_q <= '0;
            idx_q    <= '0;
          end
        end
        S_READ: begin
          rv_q <= v_q[idx_q];
          rw_q <= w_q[idx_q];
          ri_q <= i_flat[32'(idx_q) * N +: N];
        end
        S_CALC: begin
          vn_q <= vn_d;
          wn_q <= wn_d;
        end
        S_UPDATE: begin
          if (vn_q >= VTH_N) begin
            v_q[idx_q]      <= C_N;
            w_q[idx_q]      <= wsp_d;
            spikes_q[idx_q] <= 1'b1;
          end else begin
            v_q[idx_q] <= vn_q;
            w_q[idx_q] <= wn_q;
          end
          if (!last_idx) idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    spikes = spikes_q;
    v_flat = '0;
    w_flat = '0;
    for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
      v_flat[k * N +: N] = v_q[k];
      w_flat[k * N +: N] = w_q[k];
    end
  end

endmodule
